// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side bus of the instruction cache responder.
// slave = cache side, master = fetch unit / memory controller side.
interface icache_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  IF2IC_en;
  logic [ADDR_WIDTH-1:0] IF2IC_addr;
  logic                  IC2IF_en;
  logic [31:0]           IC2IF_data;
  logic                  RoB2IC_flush;
  logic                  IC2MC_en;
  logic [ADDR_WIDTH-1:0] IC2MC_addr;
  logic                  MC2IC_en;
  logic [31:0]           MC2IC_data;

  modport slave (
    input  IF2IC_en, IF2IC_addr, RoB2IC_flush, MC2IC_en, MC2IC_data,
    output IC2IF_en, IC2IF_data, IC2MC_en, IC2MC_addr
  );

  modport master (
    output IF2IC_en, IF2IC_addr, RoB2IC_flush, MC2IC_en, MC2IC_data,
    input  IC2IF_en, IC2IF_data, IC2MC_en, IC2MC_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache with word-by-word line refill and 1-cycle hit response.
// Optional hit/miss counters are built when macro ICACHE_STATS_EN is defined.
module icache_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CACHE_WIDTH = 8,
  parameter int BLOCK_WIDTH = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WORDS = 1 << BLOCK_WIDTH;
  localparam int LINES = 1 << CACHE_WIDTH;
  localparam int OFF   = BLOCK_WIDTH + 2;
  localparam int TAG_W = ADDR_WIDTH - CACHE_WIDTH - OFF;
  localparam logic [BLOCK_WIDTH-1:0] LAST_WORD = '1;

  typedef logic [WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

  logic [TAG_W-1:0]       r_tag_mem [LINES];
  line_t                  r_data_mem [LINES];
  logic [LINES-1:0]       r_valid;
  state_t                 r_state, w_state_next;
  logic [BLOCK_WIDTH-1:0] r_cnt, r_word;
  line_t                  r_line_buf, w_fill_line;
  logic                   r_flush_pend, r_resp_en, r_mc_en;
  logic [31:0]            r_resp_data;
  logic [ADDR_WIDTH-1:0]  r_mc_addr;

  logic [CACHE_WIDTH-1:0] w_index, w_fill_index;
  logic [BLOCK_WIDTH-1:0] w_word;
  logic [TAG_W-1:0]       w_tag, w_fill_tag;
  logic                   w_hit, w_accept_hit, w_accept_miss, w_last, w_fill_resp, w_resp_fire;
  logic                   w_unused_addr;

  assign w_index       = bus.IF2IC_addr[OFF +: CACHE_WIDTH];
  assign w_word        = bus.IF2IC_addr[2 +: BLOCK_WIDTH];
  assign w_tag         = bus.IF2IC_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit         = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
  assign w_unused_addr = &{1'b0, bus.IF2IC_addr[1:0]};
  // The refill address register doubles as the latched tag/index of the line being filled.
  assign w_fill_index  = r_mc_addr[OFF +: CACHE_WIDTH];
  assign w_fill_tag    = r_mc_addr[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    w_state_next         = r_state;
    w_accept_hit         = 1'b0;
    w_accept_miss        = 1'b0;
    w_last               = 1'b0;
    w_fill_resp          = 1'b0;
    w_fill_line          = r_line_buf;
    w_fill_line[r_cnt]   = bus.MC2IC_data;
    case (r_state)
      S_IDLE: begin
        if (!bus.RoB2IC_flush && bus.IF2IC_en) begin
          if (w_hit) begin
            w_accept_hit = 1'b1;
            w_state_next = S_RESP;
          end else begin
            w_accept_miss = 1'b1;
            w_state_next  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (bus.MC2IC_en && (r_cnt == LAST_WORD)) begin
          w_last = 1'b1;
          if (r_flush_pend || bus.RoB2IC_flush) begin
            w_state_next = S_IDLE;
          end else begin
            w_fill_resp  = 1'b1;
            w_state_next = S_RESP;
          end
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_line_buf   <= '0;
      r_flush_pend <= 1'b0;
      r_resp_en    <= 1'b0;
      r_resp_data  <= '0;
      r_mc_en      <= 1'b0;
      r_mc_addr    <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_next;
      r_resp_en   <= 1'b0;
      r_resp_data <= '0;
      if (w_accept_hit) begin
        r_resp_en   <= 1'b1;
        r_resp_data <= r_data_mem[w_index][w_word];
      end
      if (w_accept_miss) begin
        r_word       <= w_word;
        r_cnt        <= '0;
        r_flush_pend <= 1'b0;
        r_mc_en      <= 1'b1;
        r_mc_addr    <= {bus.IF2IC_addr[ADDR_WIDTH-1:OFF], {BLOCK_WIDTH{1'b0}}, 2'b00};
      end
      if (r_state == S_REFILL) begin
        // A flush during refill is remembered so the fill finishes silently.
        if (bus.RoB2IC_flush) r_flush_pend <= 1'b1;
        if (bus.MC2IC_en) begin
          r_line_buf[r_cnt] <= bus.MC2IC_data;
          r_cnt             <= r_cnt + 1'b1;
          if (w_last) begin
            r_valid[w_fill_index] <= 1'b1;
            r_mc_en               <= 1'b0;
            if (w_fill_resp) begin
              r_resp_en   <= 1'b1;
              r_resp_data <= w_fill_line[r_word];
            end
          end else begin
            r_mc_addr <= r_mc_addr + ADDR_WIDTH'(4);
          end
        end
      end
    end
  end

  // Tag/data arrays carry no reset so they map onto RAM; valid bits gate their contents.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_last) begin
      r_tag_mem[w_fill_index]  <= w_fill_tag;
      r_data_mem[w_fill_index] <= w_fill_line;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in) begin
      if (w_accept_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (w_accept_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  // A flush arriving in the response cycle still kills the pulse.
  assign w_resp_fire    = r_resp_en & ~bus.RoB2IC_flush;
  assign bus.IC2IF_en   = w_resp_fire;
  assign bus.IC2IF_data = w_resp_fire ? r_resp_data : 32'd0;
  assign bus.IC2MC_en   = r_mc_en;
  assign bus.IC2MC_addr = r_mc_addr;

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: expected pulses and refill addresses are queued
// by the stimulus and consumed by the monitor and the memory model.
module tb_icache_responder;
  logic clk = 1'b0;
  logic rst, rdy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mc_words = 0;
  int mc_last_cyc = 0;
  int pulse_cyc = 0;
  int pulse_cnt = 0;
  int mem_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mc_q[$];

  icache_responder_if #(.ADDR_WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  icache_responder dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus),
                        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  icache_responder dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory controller model: one word every second cycle while a refill is requested.
  always @(negedge clk) begin
    bus.MC2IC_en   = 1'b0;
    bus.MC2IC_data = 32'd0;
    if (rst) begin
      mem_cnt = 0;
    end else if (rdy && bus.IC2MC_en) begin
      if (mem_cnt == 1) begin
        mem_cnt = 0;
        bus.MC2IC_en   = 1'b1;
        bus.MC2IC_data = {16'hA5A5, bus.IC2MC_addr[15:0]};
        mc_words++;
        mc_last_cyc = cyc;
        checks++;
        if (mc_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_refill got addr=%h expected none", bus.IC2MC_addr);
        end else begin
          logic [31:0] ea;
          ea = mc_q.pop_front();
          if (bus.IC2MC_addr !== ea) begin
            failures++;
            $display("FAIL refill_addr got %h expected %h", bus.IC2MC_addr, ea);
          end
        end
      end else begin
        mem_cnt++;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (bus.IC2IF_en === 1'b1) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got data=%h expected no pulse", bus.IC2IF_data);
      end else begin
        logic [31:0] ed;
        ed = exp_q.pop_front();
        if (bus.IC2IF_data !== ed) begin
          failures++;
          $display("FAIL resp_data got %h expected %h", bus.IC2IF_data, ed);
        end else begin
          $display("resp data=%h at cycle %0d", bus.IC2IF_data, cyc);
        end
      end
    end else if (!rst) begin
      checks++;
      if (bus.IC2IF_data !== 32'd0) begin
        failures++;
        $display("FAIL idle_data got %h expected 00000000", bus.IC2IF_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr);
    bus.IF2IC_en   = 1'b1;
    bus.IF2IC_addr = addr;
    $display("req addr=%h", addr);
    tick();
    bus.IF2IC_en = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mc_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(exp_q.size() + mc_q.size()), 32'd0);
    tick();
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (mc_words < target && n < 40) begin
      tick();
      n++;
    end
    check("word_wait_timeout", 32'(mc_words >= target), 32'd1);
  endtask

  task automatic wait_fill_done();
    int n = 0;
    while (bus.IC2MC_en && n < 40) begin
      tick();
      n++;
    end
    check("fill_done_timeout", 32'(bus.IC2MC_en), 32'd0);
    tick();
    tick();
  endtask

  task automatic hit_now(input string name);
    @(negedge clk);
    #1;
    check({name, "_latency"}, 32'(bus.IC2IF_en), 32'd1);
    check({name, "_no_mc"}, 32'(bus.IC2MC_en), 32'd0);
  endtask

  initial begin
    int base;
    int pc0;
    rst = 1'b1;
    rdy = 1'b1;
    bus.IF2IC_en     = 1'b0;
    bus.IF2IC_addr   = 32'd0;
    bus.RoB2IC_flush = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_ic2if_en", 32'(bus.IC2IF_en), 32'd0);
    check("rst_ic2if_data", bus.IC2IF_data, 32'd0);
    check("rst_ic2mc_en", 32'(bus.IC2MC_en), 32'd0);
    check("rst_ic2mc_addr", bus.IC2MC_addr, 32'd0);
    tick();
    rst = 1'b0;

    // Cold miss
    mc_q.push_back(32'h1000); mc_q.push_back(32'h1004); exp_q.push_back(32'hA5A51004);
    issue(32'h1004);
    @(negedge clk);
    check("cold_mc_en", 32'(bus.IC2MC_en), 32'd1);
    check("cold_mc_addr", bus.IC2MC_addr, 32'h1000);
    wait_resp("cold");
    check("cold_latency", 32'(pulse_cyc - mc_last_cyc), 32'd1);

    // Hit on the other word of the line
    exp_q.push_back(32'hA5A51000);
    issue(32'h1000);
    hit_now("hit");
    wait_resp("hit");

    // Conflict eviction and re-miss
    mc_q.push_back(32'h1800); mc_q.push_back(32'h1804); exp_q.push_back(32'hA5A51800);
    issue(32'h1800);
    wait_resp("conflict");
    mc_q.push_back(32'h1000); mc_q.push_back(32'h1004); exp_q.push_back(32'hA5A51000);
    issue(32'h1000);
    wait_resp("remiss");

    // Flush between the two refill words
    base = mc_words;
    mc_q.push_back(32'h2008); mc_q.push_back(32'h200C);
    issue(32'h2008);
    wait_words(base + 1);
    bus.RoB2IC_flush = 1'b1;
    tick();
    bus.RoB2IC_flush = 1'b0;
    wait_fill_done();
    check("flush_fill_words", 32'(mc_words - base), 32'd2);
    exp_q.push_back(32'hA5A5200C);
    issue(32'h200C);
    hit_now("flush_line_hit");
    wait_resp("flush_line_hit");

    // Held request: one pulse per accepted request
    pc0 = pulse_cnt;
    exp_q.push_back(32'hA5A51000); exp_q.push_back(32'hA5A51000);
    bus.IF2IC_en = 1'b1; bus.IF2IC_addr = 32'h1000;
    $display("req held addr=%h for 4 cycles", bus.IF2IC_addr);
    repeat (4) tick();
    bus.IF2IC_en = 1'b0;
    wait_resp("held");
    check("held_pulses", 32'(pulse_cnt - pc0), 32'd2);

    // Flush with request in IDLE: nothing accepted
    bus.RoB2IC_flush = 1'b1;
    issue(32'h1000);
    bus.RoB2IC_flush = 1'b0;
    @(negedge clk);
    check("idle_flush_en", 32'(bus.IC2IF_en), 32'd0);
    tick();

    // Flush during the response cycle kills the pulse
    issue(32'h1000);
    bus.RoB2IC_flush = 1'b1;
    @(negedge clk);
    check("resp_flush_en", 32'(bus.IC2IF_en), 32'd0);
    check("resp_flush_data", bus.IC2IF_data, 32'd0);
    tick();
    bus.RoB2IC_flush = 1'b0;
    tick();

    // Stall mid-refill
    base = mc_words;
    mc_q.push_back(32'h4010); mc_q.push_back(32'h4014); exp_q.push_back(32'hA5A54010);
    issue(32'h4010);
    wait_words(base + 1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_mc_en", 32'(bus.IC2MC_en), 32'd1);
      check("stall_mc_addr", bus.IC2MC_addr, 32'h4014);
      check("stall_pulse", 32'(bus.IC2IF_en), 32'd0);
    end
    rdy = 1'b1;
    wait_resp("stall");

    // Flush coinciding with the last refill word: line written, no pulse
    base = mc_words;
    mc_q.push_back(32'h6000); mc_q.push_back(32'h6004);
    issue(32'h6000);
    wait_words(base + 1);
    tick();
    bus.RoB2IC_flush = 1'b1;
    tick();
    bus.RoB2IC_flush = 1'b0;
    wait_fill_done();
    exp_q.push_back(32'hA5A56004);
    issue(32'h6004);
    hit_now("coinc_hit");
    wait_resp("coinc_hit");

    // Reset mid-refill
    base = mc_words;
    mc_q.push_back(32'h5020);
    issue(32'h5020);
    wait_words(base + 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_refill_mc_en", 32'(bus.IC2MC_en), 32'd0);
    check("rst_refill_pulse", 32'(bus.IC2IF_en), 32'd0);
    tick();
    mc_q.push_back(32'h5020); mc_q.push_back(32'h5024); exp_q.push_back(32'hA5A55020);
    issue(32'h5020);
    wait_resp("after_rst_line");
    mc_q.push_back(32'h1000); mc_q.push_back(32'h1004); exp_q.push_back(32'hA5A51004);
    issue(32'h1004);
    wait_resp("after_rst_cold");

    repeat (3) tick();
    check("final_resp_queue", 32'(exp_q.size()), 32'd0);
    check("final_mc_queue", 32'(mc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning fetch address width.
REQ-002 SHALL have parameter CACHE_WIDTH, default 8, meaning log2 of the line count (256 lines).
REQ-003 SHALL have parameter BLOCK_WIDTH, default 1, meaning log2 of words per line (2 words, 8 bytes).
REQ-004 SHALL have port clk_in, input, 1, the only clock.
REQ-005 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rdy_in, input, 1, global enable; when low, all state holds.
REQ-007 SHALL have port IF2IC_en, input, 1, fetch request valid.
REQ-008 SHALL have port IF2IC_addr, input, ADDR_WIDTH, fetch byte address; bits [1:0] are always 0.
REQ-009 SHALL have port IC2IF_en, output, 1, one-cycle response pulse.
REQ-010 SHALL have port IC2IF_data, output, 32, instruction word returned with the pulse.
REQ-011 SHALL have port RoB2IC_flush, input, 1, misprediction flush; kills any pending response.
REQ-012 SHALL have port IC2MC_en, output, 1, word read request to the memory controller.
REQ-013 SHALL have port IC2MC_addr, output, ADDR_WIDTH, word-aligned refill address.
REQ-014 SHALL have port MC2IC_en, input, 1, refill word valid.
REQ-015 SHALL have port MC2IC_data, input, 32, refill word.

Function
REQ-016 SHALL be direct-mapped: index = addr[10:3], word select = addr[2], tag = addr[31:11] (21 bits), with one valid bit per line.
REQ-017 SHALL use three FSM states: IDLE, REFILL, RESP.
REQ-018 In IDLE with IF2IC_en=1 and a hit, SHALL go to RESP; in RESP it SHALL drive IC2IF_en=1 and IC2IF_data=word for exactly one cycle, so response latency is 1 cycle.
REQ-019 In IDLE with IF2IC_en=1 and a miss, SHALL latch the address, clear the word counter, and enter REFILL.
REQ-020 In REFILL, SHALL hold IC2MC_en=1 with IC2MC_addr={tag,index,counter,2'b00}; on each MC2IC_en it SHALL store the word into the line buffer and increment the counter.
REQ-021 On the MC2IC_en of the last word (counter=1), SHALL write the tag and data, set valid, and go to RESP; IC2MC_en SHALL be 0 in the cycle after that.
REQ-022 In RESP, SHALL return to IDLE and ignore IF2IC_en in that cycle, which prevents a duplicate fetch of the old pc.
REQ-023 SHALL ignore IF2IC_en in REFILL; no request queueing.
REQ-024 On RoB2IC_flush in IDLE or RESP, SHALL suppress the IC2IF_en pulse and go to IDLE.
REQ-025 On RoB2IC_flush in REFILL, SHALL complete the line fill (outstanding memory words are not abandoned), then go to IDLE without a response pulse.
REQ-026 When flush and the last MC2IC_en coincide, SHALL write the line, set valid, and emit no pulse.
REQ-027 SHALL drive IC2IF_data=0 whenever IC2IF_en=0.
REQ-028 With rdy_in=0, SHALL freeze the FSM, counters and arrays; registered outputs hold their values.

Reset
REQ-029 rst_in SHALL clear all valid bits, the FSM (to IDLE), the word counter, IC2IF_en, IC2IF_data, IC2MC_en and IC2MC_addr to 0 in one cycle.
REQ-030 Reset during REFILL SHALL abandon the fill, leave the line invalid, and produce no pulse.
REQ-031 Reset SHALL take priority over rdy_in and RoB2IC_flush.

Configuration
REQ-032 With macro ICACHE_STATS_EN defined, SHALL add output ports hit_cnt[31:0] and miss_cnt[31:0].
REQ-033 With ICACHE_STATS_EN defined, counters SHALL increment once per accepted hit or miss, wrap at 2^32, and reset to 0.
REQ-034 Without ICACHE_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-035 Cold miss: after reset, request 0x0000_1004 -> IC2MC_addr 0x1000 then 0x1004 -> one IC2IF_en pulse carrying the 0x1004 word one cycle after the second MC2IC_en.
REQ-036 Hit: then request 0x0000_1000 -> IC2IF_en the next cycle with the 0x1000 word, and no IC2MC_en.
REQ-037 Conflict: request 0x0000_1800 (same index, new tag) -> refill; a later 0x1000 misses again.
REQ-038 Flush mid-refill: assert RoB2IC_flush between the two MC2IC_en -> fill completes, no pulse, a later request to the same line hits.
REQ-039 Held request: IF2IC_en held high across RESP -> exactly one pulse per accepted request, never a duplicate in the RESP cycle.
REQ-040 Stall and reset: rdy_in=0 for 5 cycles mid-REFILL -> no state change; rst_in mid-REFILL -> IC2MC_en=0 next cycle and the line stays invalid.
